// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants and types for the round-robin demux sequencer
package demux_pkg;

    localparam int         N_OUT    = 4;
    localparam int         SEL_W    = 2;
    localparam logic [7:0] SKIP_MAX = 8'hFF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Next output index; wraps 3 -> 0 through the natural SEL_W-bit overflow.
    function automatic logic [SEL_W-1:0] sel_next(input logic [SEL_W-1:0] s);
        return s + 1'b1;
    endfunction

endpackage

// File: rtl/demux_gate.sv
// rtl/demux_gate.sv - gate-level 1-to-4 demux: routes D onto output S
module demux_gate (
    input  logic       i_d,
    input  logic [1:0] i_s,
    output logic [3:0] o_y
);

    logic w_s0_n;
    logic w_s1_n;

    not u_inv0 (w_s0_n, i_s[0]);
    not u_inv1 (w_s1_n, i_s[1]);

    and u_and0 (o_y[0], i_d, w_s1_n, w_s0_n);
    and u_and1 (o_y[1], i_d, w_s1_n, i_s[0]);
    and u_and2 (o_y[2], i_d, i_s[1],  w_s0_n);
    and u_and3 (o_y[3], i_d, i_s[1],  i_s[0]);

endmodule

// File: rtl/demux_rr_sched.sv
// rtl/demux_rr_sched.sv - round-robin sequencer with timeout re-target driving demux_gate
module demux_rr_sched
    import demux_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             fix_en,
    input  logic [SEL_W-1:0] fix_sel,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [SEL_W-1:0] sel,
    output logic [N_OUT-1:0] out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic [N_OUT-1:0] out_ready,
    output logic [7:0]       skip_cnt
);

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SEL_W-1:0]   r_sel;
    logic [SEL_W-1:0]   r_rr_ptr;
    logic [WIDTH-1:0]   r_data;
    logic [7:0]         r_timer;
    logic [7:0]         r_skip;
    logic               r_fix;

    logic               w_hold;
    logic               w_hs;
    logic               w_in_ready;
    logic               w_acc;
    logic               w_expire;
    logic [SEL_W-1:0]   w_rr_next;

    assign w_hold    = (r_state == ST_HOLD);
    assign w_hs      = w_hold && out_ready[r_sel];
    assign w_acc     = in_valid && w_in_ready;
    assign w_expire  = w_hold && !r_fix && !w_hs && (r_timer == TIMER_LAST);
    // Pointer moves past the sink that just took a word, so a same-cycle accept already sees it.
    assign w_rr_next = (w_hs && !r_fix) ? sel_next(r_sel) : r_rr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = enable;
                if (in_valid && enable) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                w_in_ready = enable && out_ready[r_sel];
                if (w_hs && !(in_valid && w_in_ready)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel    <= '0;
            r_rr_ptr <= '0;
            r_data   <= '0;
            r_timer  <= '0;
            r_skip   <= '0;
            r_fix    <= 1'b0;
        end else begin
            r_rr_ptr <= w_rr_next;
            if (w_acc) begin
                r_data  <= in_data;
                r_sel   <= fix_en ? fix_sel : w_rr_next;
                r_fix   <= fix_en;
                r_timer <= '0;
            end else if (w_hold && !w_hs) begin
                // Fixed-route words wait forever; otherwise rotate to the next sink on expiry.
                if (r_fix) begin
                    r_timer <= '0;
                end else if (w_expire) begin
                    r_sel   <= sel_next(r_sel);
                    r_timer <= '0;
                    if (r_skip != SKIP_MAX) begin
                        r_skip <= r_skip + 8'd1;
                    end
                end else begin
                    r_timer <= r_timer + 8'd1;
                end
            end
        end
    end

    demux_gate u_demux_gate (
        .i_d (w_hold),
        .i_s (r_sel),
        .o_y (out_valid)
    );

    // Held low through reset so the producer never sees a ready before release.
    assign in_ready = w_in_ready && rst_n;
    assign sel      = r_sel;
    assign out_data = r_data;
    assign skip_cnt = r_skip;

endmodule

// File: tb/tb_demux_rr_sched.sv
// tb/tb_demux_rr_sched.sv - self-checking bench for demux_rr_sched against a transaction model
module tb_demux_rr_sched;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       enable    = 1'b1;
    logic       fix_en    = 1'b0;
    logic [1:0] fix_sel   = 2'd0;
    logic       in_valid  = 1'b0;
    logic [7:0] in_data   = 8'd0;
    logic [3:0] out_ready = 4'd0;
    logic       in_ready;
    logic [1:0] sel;
    logic [3:0] out_valid;
    logic [7:0] out_data;
    logic [7:0] skip_cnt;

    int total = 0;
    int bad   = 0;
    int exp_ptr  = 0;
    int exp_skip = 0;
    int cyc = 0;
    int onehot_bad = 0;

    logic [1:0] dport_q[$];
    logic [7:0] ddata_q[$];
    int         dcyc_q[$];
    logic [7:0] acc_q[$];

    demux_rr_sched #(.WIDTH(8), .TIMEOUT(15)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .fix_en    (fix_en),
        .fix_sel   (fix_sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .skip_cnt  (skip_cnt)
    );

    always #5 clk = ~clk;

    always begin
        @(negedge clk);
        #4;
        cyc++;
        if (rst_n) begin
            if (!$onehot0(out_valid)) onehot_bad++;
            for (int k = 0; k < 4; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    dport_q.push_back(2'(k));
                    ddata_q.push_back(out_data);
                    dcyc_q.push_back(cyc);
                end
            end
            if (in_valid && in_ready) acc_q.push_back(in_data);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at time limit, want finished");
        $fatal(1);
    end

    // A word is offered to the pointer's sink; every sink that stays not-ready costs one skip.
    function automatic logic [1:0] model_word(input logic [3:0] mask, input bit fx, input logic [1:0] fs);
        int t;
        if (fx) return fs;
        t = exp_ptr;
        while (mask[t] == 1'b0) begin
            t = (t + 1) % 4;
            if (exp_skip < 255) exp_skip++;
        end
        exp_ptr = (t + 1) % 4;
        return 2'(t);
    endfunction

    task automatic clr();
        dport_q.delete();
        ddata_q.delete();
        dcyc_q.delete();
        acc_q.delete();
    endtask

    task automatic push_word(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 400; i++) begin
            #4;
            if (in_ready) begin
                @(negedge clk);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        total++; bad++;
        $display("FAIL push_timeout data=%h in_ready never 1, want 1", d);
    endtask

    task automatic wait_del(input int n);
        int i;
        i = 0;
        while (dport_q.size() < n && i < 5000) begin
            @(negedge clk);
            i++;
        end
        total++;
        if (dport_q.size() < n) begin
            bad++;
            $display("FAIL wait_del got=%0d deliveries want=%0d", dport_q.size(), n);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if (out_valid !== 4'b0000 || sel !== 2'd0 || skip_cnt !== 8'd0 || out_data !== 8'd0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_values out_valid=%b sel=%0d skip=%0d data=%h in_ready=%b want 0000 0 0 00 0",
                     out_valid, sel, skip_cnt, out_data, in_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || out_valid !== 4'b0000) begin
            bad++;
            $display("FAIL idle_after_reset in_ready=%b out_valid=%b want 1 0000", in_ready, out_valid);
        end
        exp_ptr = 0;
        exp_skip = 0;
    endtask

    task automatic test_rr_wrap();
        logic [1:0] p;
        out_ready = 4'b1111;
        clr();
        for (int i = 0; i < 5; i++) push_word(8'hA0 + 8'(i));
        wait_del(5);
        repeat (3) @(negedge clk);
        total++;
        if (dport_q.size() !== 5) begin
            bad++;
            $display("FAIL rr_wrap_count got=%0d want=5", dport_q.size());
        end
        for (int i = 0; i < 5; i++) begin
            p = model_word(4'b1111, 1'b0, 2'd0);
            total++;
            if (dport_q[i] !== p || ddata_q[i] !== 8'hA0 + 8'(i) || dcyc_q[i] !== dcyc_q[0] + i) begin
                bad++;
                $display("FAIL rr_wrap[%0d] port=%0d data=%h cyc=+%0d want port=%0d data=%h cyc=+%0d",
                         i, dport_q[i], ddata_q[i], dcyc_q[i] - dcyc_q[0], p, 8'hA0 + 8'(i), i);
            end
        end
    endtask

    task automatic test_timeout();
        int n_ok;
        logic [1:0] p;
        out_ready = 4'b1101;
        clr();
        push_word(8'h55);
        n_ok = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid === 4'b0010) n_ok++;
            @(negedge clk);
        end
        total++;
        if (n_ok !== 15 || out_valid !== 4'b0100) begin
            bad++;
            $display("FAIL timeout_window cycles_on_out1=%0d then out_valid=%b want 15 then 0100", n_ok, out_valid);
        end
        wait_del(1);
        p = model_word(4'b1101, 1'b0, 2'd0);
        total++;
        if (dport_q[0] !== p || ddata_q[0] !== 8'h55 || skip_cnt !== 8'(exp_skip)) begin
            bad++;
            $display("FAIL timeout_deliver port=%0d data=%h skip=%0d want port=%0d data=55 skip=%0d",
                     dport_q[0], ddata_q[0], skip_cnt, p, exp_skip);
        end
        push_word(8'h56);
        wait_del(2);
        p = model_word(4'b1101, 1'b0, 2'd0);
        total++;
        if (dport_q[1] !== p || ddata_q[1] !== 8'h56) begin
            bad++;
            $display("FAIL timeout_next port=%0d data=%h want port=%0d data=56", dport_q[1], ddata_q[1], p);
        end
    endtask

    task automatic test_fixed();
        logic [1:0] p;
        fix_en = 1'b1;
        fix_sel = 2'd2;
        out_ready = 4'b1011;
        clr();
        fork
            begin
                push_word(8'hB0);
                push_word(8'hB1);
                push_word(8'hB2);
            end
            begin
                repeat (40) @(negedge clk);
                total++;
                if (dport_q.size() !== 0 || out_valid !== 4'b0100 || skip_cnt !== 8'(exp_skip)) begin
                    bad++;
                    $display("FAIL fixed_stall deliveries=%0d out_valid=%b skip=%0d want 0 0100 %0d",
                             dport_q.size(), out_valid, skip_cnt, exp_skip);
                end
                out_ready = 4'b1111;
            end
        join
        wait_del(3);
        for (int i = 0; i < 3; i++) begin
            p = model_word(4'b1011, 1'b1, 2'd2);
            total++;
            if (dport_q[i] !== p || ddata_q[i] !== 8'hB0 + 8'(i)) begin
                bad++;
                $display("FAIL fixed[%0d] port=%0d data=%h want port=%0d data=%h", i, dport_q[i], ddata_q[i], p, 8'hB0 + 8'(i));
            end
        end
        total++;
        if (skip_cnt !== 8'(exp_skip)) begin
            bad++;
            $display("FAIL fixed_skip skip=%0d want=%0d", skip_cnt, exp_skip);
        end
        fix_en = 1'b0;
        push_word(8'hB3);
        wait_del(4);
        p = model_word(4'b1111, 1'b0, 2'd0);
        total++;
        if (dport_q[3] !== p || ddata_q[3] !== 8'hB3) begin
            bad++;
            $display("FAIL fixed_ptr_kept port=%0d data=%h want port=%0d data=b3", dport_q[3], ddata_q[3], p);
        end
    endtask

    task automatic test_expiry_edge();
        logic [1:0] p;
        logic [3:0] want_v;
        out_ready = 4'b0000;
        clr();
        want_v = 4'b0001 << exp_ptr;
        push_word(8'h77);
        repeat (14) @(negedge clk);
        total++;
        if (out_valid !== want_v) begin
            bad++;
            $display("FAIL expiry_pre out_valid=%b want=%b", out_valid, want_v);
        end
        out_ready = want_v;
        wait_del(1);
        p = model_word(want_v, 1'b0, 2'd0);
        total++;
        if (dport_q[0] !== p || ddata_q[0] !== 8'h77 || skip_cnt !== 8'(exp_skip)) begin
            bad++;
            $display("FAIL expiry_edge port=%0d data=%h skip=%0d want port=%0d data=77 skip=%0d",
                     dport_q[0], ddata_q[0], skip_cnt, p, exp_skip);
        end
    endtask

    task automatic test_enable_drop();
        logic [1:0] p;
        out_ready = 4'b0000;
        clr();
        push_word(8'h88);
        enable = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h99;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL enable_hold_ready in_ready=%b want 0", in_ready);
        end
        @(negedge clk);
        out_ready = 4'b1111;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL enable_gate_ready in_ready=%b want 0", in_ready);
        end
        wait_del(1);
        p = model_word(4'b1111, 1'b0, 2'd0);
        repeat (3) @(negedge clk);
        total++;
        if (dport_q[0] !== p || ddata_q[0] !== 8'h88 || in_ready !== 1'b0 || acc_q.size() !== 1 || out_valid !== 4'b0000) begin
            bad++;
            $display("FAIL enable_drop port=%0d data=%h in_ready=%b accepts=%0d out_valid=%b want port=%0d 88 0 1 0000",
                     dport_q[0], ddata_q[0], in_ready, acc_q.size(), out_valid, p);
        end
        enable = 1'b1;
        push_word(8'h99);
        wait_del(2);
        p = model_word(4'b1111, 1'b0, 2'd0);
        total++;
        if (dport_q[1] !== p || ddata_q[1] !== 8'h99) begin
            bad++;
            $display("FAIL enable_resume port=%0d data=%h want port=%0d data=99", dport_q[1], ddata_q[1], p);
        end
    endtask

    task automatic test_skip_saturate();
        int want_p;
        out_ready = 4'b0000;
        clr();
        want_p = (exp_ptr + 260) % 4;
        push_word(8'h5A);
        repeat (3900) @(negedge clk);
        exp_skip = (exp_skip + 260 > 255) ? 255 : exp_skip + 260;
        total++;
        if (skip_cnt !== 8'(exp_skip) || out_valid !== (4'b0001 << want_p)) begin
            bad++;
            $display("FAIL skip_saturate skip=%0d out_valid=%b want skip=%0d out_valid=%b",
                     skip_cnt, out_valid, exp_skip, 4'b0001 << want_p);
        end
        out_ready = 4'b1111;
        wait_del(1);
        exp_ptr = (want_p + 1) % 4;
        total++;
        if (dport_q[0] !== 2'(want_p) || ddata_q[0] !== 8'h5A || skip_cnt !== 8'(exp_skip)) begin
            bad++;
            $display("FAIL saturate_deliver port=%0d data=%h skip=%0d want port=%0d data=5a skip=%0d",
                     dport_q[0], ddata_q[0], skip_cnt, want_p, exp_skip);
        end
    endtask

    task automatic test_async_reset();
        logic [1:0] p;
        out_ready = 4'b0000;
        clr();
        push_word(8'hC3);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 4'b0000 || sel !== 2'd0 || skip_cnt !== 8'd0 || out_data !== 8'd0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL async_reset out_valid=%b sel=%0d skip=%0d data=%h in_ready=%b want 0000 0 0 00 0",
                     out_valid, sel, skip_cnt, out_data, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_ptr = 0;
        exp_skip = 0;
        out_ready = 4'b1111;
        push_word(8'hC4);
        wait_del(1);
        p = model_word(4'b1111, 1'b0, 2'd0);
        repeat (20) @(negedge clk);
        total++;
        if (dport_q.size() !== 1 || dport_q[0] !== p || ddata_q[0] !== 8'hC4) begin
            bad++;
            $display("FAIL post_reset count=%0d port=%0d data=%h want 1 port=%0d data=c4",
                     dport_q.size(), dport_q[0], ddata_q[0], p);
        end
    endtask

    task automatic test_random();
        logic [3:0] mask;
        logic [1:0] fs;
        logic [1:0] p;
        logic [7:0] d;
        bit fx;
        for (int w = 0; w < 24; w++) begin
            mask = 4'($urandom_range(1, 15));
            fx = ($urandom_range(0, 3) == 0);
            fs = 2'($urandom_range(0, 3));
            while (mask[fs] == 1'b0) fs = 2'($urandom_range(0, 3));
            d = 8'($urandom);
            fix_en = fx;
            fix_sel = fs;
            out_ready = mask;
            clr();
            push_word(d);
            wait_del(1);
            p = model_word(mask, fx, fs);
            total++;
            if (dport_q[0] !== p || ddata_q[0] !== d || skip_cnt !== 8'(exp_skip)) begin
                bad++;
                $display("FAIL random[%0d] mask=%b fix=%0d port=%0d data=%h skip=%0d want port=%0d data=%h skip=%0d",
                         w, mask, fx, dport_q[0], ddata_q[0], skip_cnt, p, d, exp_skip);
            end
        end
        fix_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rr_wrap();
        test_timeout();
        test_fixed();
        test_expiry_edge();
        test_enable_drop();
        test_random();
        test_skip_saturate();
        test_async_reset();
        total++;
        if (onehot_bad !== 0) begin
            bad++;
            $display("FAIL onehot_check violations=%0d want=0", onehot_bad);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
